uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser_if.sv | 24 ++
 rtl/uart_cmd_parser.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// Register-bus link between the UART command parser (master) and the bus fabric (slave).
// Signal suffixes are from the parser's point of view: _o driven by it, _i driven by the fabric.
// One request outstanding at a time; req_o is held until ack_i.
interface uart_cmd_parser_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [AddrWidth-1:0] address_o;
  logic [DataWidth-1:0] data_o;
  logic                 we_o;
  logic                 req_o;
  logic                 ack_i;
  logic [DataWidth-1:0] rd_data_i;

  modport master (
    output address_o, data_o, we_o, req_o,
    input  ack_i, rd_data_i
  );

  modport slave (
    input  address_o, data_o, we_o, req_o,
    output ack_i, rd_data_i
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses "wFPGA,<A>,<D>\n" / "rFPGA,<A>\n" UART lines into single register-bus transactions.
// Latency: req_o rises 2 cycles after the cycle carrying the final '\n'; ack_i bounded by TimeoutCycles.
// Backpressure: none on rx (bytes arriving mid-transaction are dropped and flagged); rsp held until rsp_ready_i.
module uart_cmd_parser #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  uart_cmd_parser_if.master    bus,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 err_o,
  output logic [1:0]           err_code_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_KEYWORD  = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;
  localparam logic [2:0] S_WAIT_ACK = 3'd5;
  localparam logic [2:0] S_RESP     = 3'd6;
  localparam logic [2:0] S_DISCARD  = 3'd7;

  localparam int TmoW = $clog2(TimeoutCycles + 1);

  localparam logic [7:0] ChNl    = 8'h0A;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChComma = 8'h2C;
  localparam logic [7:0] ChW     = 8'h77;
  localparam logic [7:0] ChR     = 8'h72;

  logic [1:0]           rst_sync_q;
  logic                 rst_core;

  logic [2:0]           state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           kw_q, kw_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [3:0]           dig_q, dig_d;
  logic                 req_q, req_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic                 ovr_q, ovr_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;

  logic                 rx_byte;
  logic                 is_nl;
  logic                 is_digit;
  logic                 ovr_now;
  logic                 ovr_any;
  logic                 syn_err;
  logic [7:0]           kw_exp;
  logic [AddrWidth-1:0] addr_next;
  logic [DataWidth-1:0] data_next;

  // Reset asserts immediately and releases on the second clk_i edge after reset_i drops.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rst_sync_q <= 2'b11;
    else         rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_core = rst_sync_q[1];

  // '\r' is invisible everywhere, so it is removed from the byte strobe up front.
  assign rx_byte   = rx_valid_i && (rx_data_i != ChCr);
  assign is_nl     = (rx_data_i == ChNl);
  assign is_digit  = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
  assign ovr_now   = rx_byte && ((state_q == S_ISSUE) || (state_q == S_WAIT_ACK) || (state_q == S_RESP));
  assign ovr_any   = ovr_q || ovr_now;
  assign addr_next = (addr_q << 3) + (addr_q << 1) + AddrWidth'(rx_data_i[3:0]);
  assign data_next = (data_q << 3) + (data_q << 1) + DataWidth'(rx_data_i[3:0]);

  // Expected keyword byte for the current match position.
  always_comb begin
    kw_exp = ChComma;
    case (kw_q)
      3'd0:    kw_exp = 8'h46;  // F
      3'd1:    kw_exp = 8'h50;  // P
      3'd2:    kw_exp = 8'h47;  // G
      3'd3:    kw_exp = 8'h41;  // A
      default: kw_exp = ChComma;
    endcase
  end

  // Line parser and bus sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    kw_d       = kw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    dig_d      = dig_q;
    req_d      = req_q;
    tmo_d      = tmo_q;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = rsp_vld_q;
    ovr_d      = ovr_any;
    err_d      = 1'b0;
    code_d     = 2'd0;
    syn_err    = 1'b0;

    // A byte during a transaction is dropped; the transaction itself carries on.
    if (ovr_now) begin
      err_d  = 1'b1;
      code_d = 2'd2;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_byte) begin
          if ((rx_data_i == ChW) || (rx_data_i == ChR)) begin
            we_d    = (rx_data_i == ChW);
            kw_d    = 3'd0;
            addr_d  = '0;
            data_d  = '0;
            dig_d   = 4'd0;
            state_d = S_KEYWORD;
          end else if (!is_nl) begin
            syn_err = 1'b1;
          end
        end
      end
      S_KEYWORD: begin
        if (rx_byte) begin
          if (rx_data_i != kw_exp)  syn_err = 1'b1;
          else if (kw_q == 3'd4)    state_d = S_ADDR;
          else                      kw_d    = kw_q + 3'd1;
        end
      end
      S_ADDR: begin
        if (rx_byte) begin
          if (is_digit) begin
            if (dig_q == 4'd10) syn_err = 1'b1;
            else begin
              addr_d = addr_next;
              dig_d  = dig_q + 4'd1;
            end
          end else if ((rx_data_i == ChComma) && we_q && (dig_q != 4'd0)) begin
            dig_d   = 4'd0;
            state_d = S_DATA;
          end else if (is_nl && !we_q && (dig_q != 4'd0)) begin
            state_d = S_ISSUE;
          end else begin
            syn_err = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (rx_byte) begin
          if (is_digit) begin
            if (dig_q == 4'd10) syn_err = 1'b1;
            else begin
              data_d = data_next;
              dig_d  = dig_q + 4'd1;
            end
          end else if (is_nl && (dig_q != 4'd0)) begin
            state_d = S_ISSUE;
          end else begin
            syn_err = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.ack_i) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = ovr_any ? S_DISCARD : S_IDLE;
            ovr_d   = 1'b0;
          end else begin
            rsp_data_d = bus.rd_data_i;
            rsp_vld_d  = 1'b1;
            state_d    = S_RESP;
          end
        end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
          // Timeout outranks a coincident overrun report.
          req_d   = 1'b0;
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = ovr_any ? S_DISCARD : S_IDLE;
          ovr_d   = 1'b0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_vld_d = 1'b0;
          state_d   = ovr_any ? S_DISCARD : S_IDLE;
          ovr_d     = 1'b0;
        end
      end
      S_DISCARD: begin
        if (rx_byte && is_nl) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A bad byte that is itself the newline has already ended the line, so no flush is needed.
    if (syn_err) begin
      err_d   = 1'b1;
      code_d  = 2'd1;
      state_d = is_nl ? S_IDLE : S_DISCARD;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_core) begin
    if (rst_core) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      kw_q       <= 3'd0;
      addr_q     <= '0;
      data_q     <= '0;
      dig_q      <= 4'd0;
      req_q      <= 1'b0;
      tmo_q      <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      kw_q       <= kw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dig_q      <= dig_d;
      req_q      <= req_d;
      tmo_q      <= tmo_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
      ovr_q      <= ovr_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign bus.address_o = addr_q;
  assign bus.data_o    = data_q;
  assign bus.we_o      = we_q;
  assign bus.req_o     = req_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_valid_o   = rsp_vld_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: command lines, bus handshakes, error codes, timeout, reset.
// Inputs are driven on the falling edge; a falling-edge monitor tallies requests, responses and errors.
// Every comparison goes through check(), which counts it and reports mismatches.
module tb_uart_cmd_parser;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  uart_cmd_parser_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  uart_cmd_parser dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .bus        (bus),
    .rsp_data_o (rsp_data),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .err_o      (err),
    .err_code_o (err_code)
  );

  int tests = 0;
  int fails = 0;
  int req_rise, req_hi, stab_bad, rsp_cyc, rsp_bad, err_tot;
  int err_cnt [4];
  int n;
  logic [31:0] last_addr, last_data, exp_rsp;
  logic        last_we, prev_req;

  // Bus/response/error activity monitor.
  always @(negedge clk) begin
    if (bus.req_o === 1'b1) begin
      req_hi++;
      if (!prev_req) begin
        req_rise++;
        last_addr = bus.address_o;
        last_data = bus.data_o;
        last_we   = bus.we_o;
      end else if (bus.address_o !== last_addr || bus.data_o !== last_data || bus.we_o !== last_we) begin
        stab_bad++;
      end
    end
    prev_req = (bus.req_o === 1'b1);
    if (rsp_valid === 1'b1) begin
      rsp_cyc++;
      if (rsp_data !== exp_rsp) rsp_bad++;
    end
    if (err === 1'b1) begin
      err_tot++;
      err_cnt[err_code]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    req_rise = 0; req_hi = 0; stab_bad = 0; rsp_cyc = 0; rsp_bad = 0; err_tot = 0;
    for (int i = 0; i < 4; i++) err_cnt[i] = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (bus.req_o !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, bus.req_o, 1);
  endtask

  task automatic do_ack(input logic [31:0] rd, input int delay);
    repeat (delay) @(negedge clk);
    bus.rd_data_i = rd;
    bus.ack_i     = 1'b1;
    @(negedge clk);
    bus.ack_i     = 1'b0;
    bus.rd_data_i = '0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rsp_ready = 1'b1;
    bus.ack_i = 1'b0; bus.rd_data_i = '0; prev_req = 1'b0; exp_rsp = '0;
    clr();
    idle(3);
    check("rst_req",      bus.req_o,     0);
    check("rst_we",       bus.we_o,      0);
    check("rst_addr",     bus.address_o, 0);
    check("rst_data",     bus.data_o,    0);
    check("rst_rsp_vld",  rsp_valid,     0);
    check("rst_rsp_data", rsp_data,      0);
    check("rst_err",      err,           0);
    check("rst_err_code", err_code,      0);
    reset = 1'b0;
    idle(4);

    // Write with ack three cycles after the request; also checks request latency.
    clr();
    send_str("wFPGA,36868,305419896\n");
    check("lat_req_low", bus.req_o, 0);
    @(negedge clk);
    check("lat_req_high", bus.req_o, 1);
    do_ack(32'h0, 3);
    check("wr_req_drop", bus.req_o, 0);
    idle(3);
    check("wr_req_cnt", req_rise, 1);
    check("wr_addr",    last_addr, 32'h0000_9004);
    check("wr_data",    last_data, 32'h1234_5678);
    check("wr_we",      last_we, 1);
    check("wr_stable",  stab_bad, 0);
    check("wr_no_rsp",  rsp_cyc, 0);
    check("wr_no_err",  err_tot, 0);

    // Read with the response held off for five cycles.
    clr();
    send_str("rFPGA,36864\n");
    wait_req("rd_req");
    check("rd_addr", bus.address_o, 32'h0000_9000);
    check("rd_we",   bus.we_o, 0);
    rsp_ready = 1'b0;
    exp_rsp   = 32'hDEAD_BEEF;
    do_ack(32'hDEAD_BEEF, 1);
    idle(5);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rd_rsp_drop",   rsp_valid, 0);
    check("rd_rsp_cycles", rsp_cyc, 6);
    check("rd_rsp_data",   rsp_bad, 0);
    check("rd_req_cnt",    req_rise, 1);
    check("rd_no_err",     err_tot, 0);

    // Empty field, then an address that wraps to zero.
    clr();
    send_str("wFPGA,,5\n");
    idle(3);
    check("empty_err1",   err_cnt[1], 1);
    check("empty_errtot", err_tot, 1);
    check("empty_no_req", req_rise, 0);
    send_str("rFPGA,4294967296\n");
    wait_req("wrap_req");
    check("wrap_addr", bus.address_o, 0);
    exp_rsp = 32'h1;
    do_ack(32'h1, 1);
    idle(3);
    check("wrap_errtot", err_tot, 1);
    check("wrap_rsp",    rsp_cyc, 1);

    // Keyword mismatch followed by blank lines and a good read.
    clr();
    send_str("rFPGB,1\n");
    send_str("\n\n");
    send_str("rFPGA,1\n");
    wait_req("kw_req");
    check("kw_addr", bus.address_o, 1);
    exp_rsp = 32'h55;
    do_ack(32'h55, 0);
    idle(3);
    check("kw_err1",    err_cnt[1], 1);
    check("kw_errtot",  err_tot, 1);
    check("kw_req_cnt", req_rise, 1);

    // Request never acknowledged.
    clr();
    send_str("rFPGA,8\n");
    n = 0;
    while ((req_rise == 0 || bus.req_o !== 1'b0) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    idle(2);
    check("tmo_req_cycles", req_hi, 1024);
    check("tmo_err3",       err_cnt[3], 1);
    check("tmo_errtot",     err_tot, 1);
    check("tmo_no_rsp",     rsp_cyc, 0);
    send_str("wFPGA,7,9\n");
    wait_req("post_tmo_req");
    do_ack(32'h0, 1);
    idle(2);
    check("post_tmo_addr", last_addr, 7);
    check("post_tmo_data", last_data, 9);
    check("post_tmo_cnt",  req_rise, 2);

    // Byte arriving during a transaction, then the rest of that line.
    clr();
    send_str("rFPGA,5\n");
    wait_req("ovr_req");
    send_byte(8'h78);
    exp_rsp = 32'h0000_CAFE;
    do_ack(32'h0000_CAFE, 1);
    idle(2);
    send_str("1\n");
    idle(2);
    send_str("wFPGA,2,3\n");
    wait_req("ovr_next_req");
    do_ack(32'h0, 1);
    idle(2);
    check("ovr_err2",    err_cnt[2], 1);
    check("ovr_errtot",  err_tot, 1);
    check("ovr_rsp",     rsp_cyc, 1);
    check("ovr_rsp_bad", rsp_bad, 0);
    check("ovr_req_cnt", req_rise, 2);
    check("ovr_addr",    last_addr, 2);
    check("ovr_data",    last_data, 3);
    check("ovr_we",      last_we, 1);

    // Eleven digits is too many; carriage returns are ignored.
    clr();
    send_str("rFPGA,00000000001\n");
    idle(2);
    check("d11_err1",   err_cnt[1], 1);
    check("d11_no_req", req_rise, 0);
    send_str("rFPGA,1");
    send_byte(8'h0D);
    send_str("2");
    send_byte(8'h0D);
    send_str("\n");
    wait_req("cr_req");
    check("cr_addr", bus.address_o, 12);
    exp_rsp = 32'h0;
    do_ack(32'h0, 0);
    idle(2);
    check("cr_errtot", err_tot, 1);

    // Reset in the middle of a transaction abandons it.
    clr();
    send_str("rFPGA,3\n");
    wait_req("mid_req");
    #1 reset = 1'b1;
    #1 check("mid_rst_req", bus.req_o, 0);
    idle(2);
    reset = 1'b0;
    idle(6);
    check("mid_rst_req_cnt", req_rise, 1);
    check("mid_rst_no_rsp",  rsp_cyc, 0);
    check("mid_rst_no_err",  err_tot, 0);
    send_str("wFPGA,11,22\n");
    wait_req("post_rst_req");
    check("post_rst_addr", bus.address_o, 11);
    check("post_rst_data", bus.data_o, 22);
    do_ack(32'h0, 1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
